// File: rtl/servo_pkg.sv
// Shared constants, channel state type and clamp helper for the servo PWM bank.
package servo_pkg;

    // Default timing for a 100 MHz clock: 20 ms frame, 1..2 ms pulse, 1.5 ms neutral.
    localparam int DEF_FRAME_CYC = 2_000_000;
    localparam int DEF_PW_MIN    = 100_000;
    localparam int DEF_PW_MAX    = 200_000;
    localparam int DEF_PW_INIT   = 150_000;

    // Channel arithmetic is carried at this width; unused upper bits are constant zero.
    localparam int SW = 32;

    typedef struct packed {
        logic [SW-1:0] target;
        logic [SW-1:0] step;
        logic [SW-1:0] cur;
    } chan_state_t;

    function automatic logic [SW-1:0] clamp(input logic [SW-1:0] val,
                                            input logic [SW-1:0] lo,
                                            input logic [SW-1:0] hi);
        if (val < lo)
            return lo;
        else if (val > hi)
            return hi;
        else
            return val;
    endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One PWM channel: holds target/step/cur, slews cur toward target once per
// frame and drives the registered pulse and busy flag.
module servo_slew_channel
    import servo_pkg::*;
#(
    parameter int W       = 21,
    parameter int PW_MIN  = DEF_PW_MIN,
    parameter int PW_MAX  = DEF_PW_MAX,
    parameter int PW_INIT = DEF_PW_INIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] cnt,
    input  logic         update,
    input  logic         wr_en,
    input  logic [W-1:0] wr_target,
    input  logic [W-1:0] wr_step,
    output logic         pwm,
    output logic         busy
);

    chan_state_t   st_q, st_d;
    logic          pwm_q, pwm_d;
    logic          busy_q, busy_d;
    logic [SW-1:0] diff;
    logic          up;

    // Next state: command write, per-frame slew, and output comparisons.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        st_d = st_q;
        diff = '0;
        up   = 1'b0;
        if (update) begin
            // Compare first so the magnitude is always a non-wrapping subtraction.
            if (st_q.target >= st_q.cur) begin
                diff = st_q.target - st_q.cur;
                up   = 1'b1;
            end else begin
                diff = st_q.cur - st_q.target;
            end
            if (st_q.step == '0 || diff <= st_q.step)
                st_d.cur = st_q.target;
            else if (up)
                st_d.cur = st_q.cur + st_q.step;
            else
                st_d.cur = st_q.cur - st_q.step;
        end
        // Commands are never accepted on the update cycle, so these never collide with slew.
        if (wr_en) begin
            st_d.target = clamp(SW'(wr_target), SW'(PW_MIN), SW'(PW_MAX));
            st_d.step   = SW'(wr_step);
        end
        pwm_d  = SW'(cnt) < st_q.cur;
        busy_d = st_q.cur != st_q.target;
    end

    // State and output registers, cleared to the neutral position on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= '{target: SW'(PW_INIT), step: '0, cur: SW'(PW_INIT)};
            pwm_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            st_q   <= st_d;
            pwm_q  <= pwm_d;
            busy_q <= busy_d;
        end
    end

    assign pwm  = pwm_q;
    assign busy = busy_q;

endmodule

// File: rtl/servo_pwm_bank.sv
// N-channel servo PWM bank: shared frame counter, command handshake and
// channel decode; per-channel slew and pulse generation live in the channels.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int FRAME_CYC = DEF_FRAME_CYC,
    parameter int PW_MIN    = DEF_PW_MIN,
    parameter int PW_MAX    = DEF_PW_MAX,
    parameter int PW_INIT   = DEF_PW_INIT,
    parameter int W         = $clog2(FRAME_CYC + 1),
    parameter int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [CHW-1:0]  cmd_ch,
    input  logic [W-1:0]    cmd_target,
    input  logic [W-1:0]    cmd_step,
    output logic [N_CH-1:0] pwm,
    output logic [N_CH-1:0] busy,
    output logic            frame_start,
    output logic            cmd_err
);

    localparam logic [W-1:0] LAST = W'(FRAME_CYC - 1);

    logic [W-1:0]    cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic            frame_start_q, frame_start_d;
    logic            cmd_err_q, cmd_err_d;
    logic            update;
    logic            accept;
    logic [N_CH-1:0] ch_hit;

    // Channel decode: an index with no matching channel is the error case.
    for (genvar g = 0; g < N_CH; g++) begin : g_hit
        assign ch_hit[g] = (cmd_ch == CHW'(g));
    end

    // Frame counter, handshake and status pulse next-state logic.
    always_comb begin
        update        = (cnt_q == LAST);
        cnt_d         = update ? '0 : cnt_q + W'(1);
        // Registered ready drops exactly on the cycle the counter sits at the update value.
        ready_d       = (cnt_d != LAST);
        accept        = cmd_valid && ready_q;
        cmd_err_d     = accept && !(|ch_hit);
        frame_start_d = (cnt_q == '0);
    end

    // Top-level registers; ready comes out of reset low and rises on the first edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            ready_q       <= 1'b0;
            frame_start_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        servo_slew_channel #(
            .W       (W),
            .PW_MIN  (PW_MIN),
            .PW_MAX  (PW_MAX),
            .PW_INIT (PW_INIT)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .cnt       (cnt_q),
            .update    (update),
            .wr_en     (accept && ch_hit[g]),
            .wr_target (cmd_target),
            .wr_step   (cmd_step),
            .pwm       (pwm[g]),
            .busy      (busy[g])
        );
    end

    assign cmd_ready   = ready_q;
    assign frame_start = frame_start_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a per-frame scoreboard of widths,
// busy snapshots and error pulses.
module tb_servo_pwm_bank;

    localparam int N_CH = 4;
    localparam int FC   = 100;
    localparam int W    = 7;
    localparam int CHW  = 3;

    logic            clk;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CHW-1:0]  cmd_ch;
    logic [W-1:0]    cmd_target;
    logic [W-1:0]    cmd_step;
    logic [N_CH-1:0] pwm;
    logic [N_CH-1:0] busy;
    logic            frame_start;
    logic            cmd_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         w[4];
        logic [3:0] b10;
        logic [3:0] b90;
        int         errs;
    } exp_t;

    exp_t sb_q[$];

    servo_pwm_bank #(
        .N_CH      (N_CH),
        .FRAME_CYC (FC),
        .PW_MIN    (10),
        .PW_MAX    (20),
        .PW_INIT   (15),
        .W         (W),
        .CHW       (CHW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_target  (cmd_target),
        .cmd_step    (cmd_step),
        .pwm         (pwm),
        .busy        (busy),
        .frame_start (frame_start),
        .cmd_err     (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int w0, input int w1, input int w2, input int w3,
                            input logic [3:0] b10, input logic [3:0] b90, input int errs);
        exp_t e;
        e.w[0] = w0; e.w[1] = w1; e.w[2] = w2; e.w[3] = w3;
        e.b10  = b10;
        e.b90  = b90;
        e.errs = errs;
        sb_q.push_back(e);
    endtask

    // Observe one frame from its first output cycle, optionally issuing one command
    // at cycle ck; hold=1 keeps cmd_valid asserted across the update cycle.
    task automatic run_frame(input bit do_cmd, input int ck, input int ch, input int tgt,
                             input int stp, input bit hold);
        int         n;
        int         cnt_w[4];
        bit         seen_low[4];
        bit         shape_ok;
        bit         fs_ok;
        int         errs;
        logic [3:0] b10;
        logic [3:0] b90;
        exp_t       e;

        n = 0;
        while (frame_start !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_sync", {31'b0, frame_start}, 1);

        for (int c = 0; c < 4; c++) begin
            cnt_w[c]    = 0;
            seen_low[c] = 1'b0;
        end
        shape_ok = 1'b1;
        fs_ok    = 1'b1;
        errs     = 0;
        b10      = 'x;
        b90      = 'x;

        for (int k = 0; k < FC; k++) begin
            if (k == 0) cmd_valid = 1'b0;
            if (k == 0 && frame_start !== 1'b1) fs_ok = 1'b0;
            if (k != 0 && frame_start !== 1'b0) fs_ok = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (pwm[c] === 1'b1) begin
                    if (seen_low[c]) shape_ok = 1'b0;
                    cnt_w[c]++;
                end else begin
                    seen_low[c] = 1'b1;
                end
            end
            if (cmd_err === 1'b1) errs++;
            if (k == 10) b10 = busy;
            if (k == 90) b90 = busy;
            if (do_cmd && k == ck) begin
                cmd_valid  = 1'b1;
                cmd_ch     = CHW'(ch);
                cmd_target = W'(tgt);
                cmd_step   = W'(stp);
                if (hold) check("ready_on_update", {31'b0, cmd_ready}, 0);
            end
            if (do_cmd && k == ck + 1) begin
                if (hold) check("ready_after_update", {31'b0, cmd_ready}, 1);
                else      cmd_valid = 1'b0;
            end
            @(negedge clk);
        end

        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            for (int c = 0; c < 4; c++)
                check($sformatf("width_ch%0d", c), cnt_w[c], e.w[c]);
            check("pulse_contiguous", {31'b0, shape_ok}, 1);
            check("frame_start_align", {31'b0, fs_ok}, 1);
            check("busy_k10", {28'b0, b10}, {28'b0, e.b10});
            check("busy_k90", {28'b0, b90}, {28'b0, e.b90});
            check("cmd_err_pulses", errs, e.errs);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_ch     = '0;
        cmd_target = '0;
        cmd_step   = '0;

        repeat (3) @(negedge clk);
        check("rst_pwm", {28'b0, pwm}, 0);
        check("rst_busy", {28'b0, busy}, 0);
        check("rst_ready", {31'b0, cmd_ready}, 0);
        check("rst_frame_start", {31'b0, frame_start}, 0);
        check("rst_cmd_err", {31'b0, cmd_err}, 0);
        rst = 1'b0;

        // Idle frames at neutral width.
        push_exp(15, 15, 15, 15, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        push_exp(15, 15, 15, 15, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);

        // ch1 jump to 20 mid-frame: visible only in the following frame.
        push_exp(15, 15, 15, 15, 4'b0000, 4'b0010, 0);
        run_frame(1, 50, 1, 20, 0, 0);
        push_exp(15, 20, 15, 15, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);

        // ch0 ramp to 10 in steps of 2: 13, 11, 10, 10.
        push_exp(15, 20, 15, 15, 4'b0000, 4'b0001, 0);
        run_frame(1, 50, 0, 10, 2, 0);
        push_exp(13, 20, 15, 15, 4'b0001, 4'b0001, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        push_exp(11, 20, 15, 15, 4'b0001, 4'b0001, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        push_exp(10, 20, 15, 15, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        push_exp(10, 20, 15, 15, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);

        // Clamping: ch2 target 5 -> 10, ch3 target 30 -> 20.
        push_exp(10, 20, 15, 15, 4'b0000, 4'b0100, 0);
        run_frame(1, 50, 2, 5, 0, 0);
        push_exp(10, 20, 10, 15, 4'b0000, 4'b1000, 0);
        run_frame(1, 50, 3, 30, 0, 0);

        // Out-of-range channel: one error pulse and no width change.
        push_exp(10, 20, 10, 20, 4'b0000, 4'b0000, 1);
        run_frame(1, 50, 5, 15, 0, 0);
        push_exp(10, 20, 10, 20, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);

        // Valid held across the update cycle: accepted one cycle late, so the
        // update is missed and the width changes a frame later.
        push_exp(10, 20, 10, 20, 4'b0000, 4'b0000, 0);
        run_frame(1, 98, 0, 20, 0, 1);
        push_exp(10, 20, 10, 20, 4'b0001, 4'b0001, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        push_exp(20, 20, 10, 20, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);

        // Reset in the middle of the pulse.
        repeat (5) @(negedge clk);
        check("pre_rst_pwm", {28'b0, pwm}, 4'hF);
        rst = 1'b1;
        #1;
        check("mid_rst_pwm", {28'b0, pwm}, 0);
        check("mid_rst_ready", {31'b0, cmd_ready}, 0);
        check("mid_rst_busy", {28'b0, busy}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        push_exp(15, 15, 15, 15, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        push_exp(15, 15, 15, 15, 4'b0000, 4'b0000, 0);
        run_frame(0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/servo_pwm_bank.md
# servo_pwm_bank

Parametrised N-channel servo PWM generator with a shared frame counter and per-channel target, slew-rate and clamp logic. It sits between the sorting-arm control FSM and the servo/hydraulic-valve output pins. It replaces fixed per-motor mode-to-pulse-width lookups with run-time programmable targets. Each channel's pulse width moves toward its target by at most a programmed step per frame, so arm joints ramp instead of jumping.

## Interface
- N_CH, 4: number of PWM channels (1..16)
- FRAME_CYC, 2_000_000: clock cycles per PWM frame (20 ms at 100 MHz)
- PW_MIN, 100_000: minimum legal pulse width, cycles
- PW_MAX, 200_000: maximum legal pulse width, cycles
- PW_INIT, 150_000: pulse width of every channel after reset (neutral)
- W, $clog2(FRAME_CYC+1): width of counter, pulse-width and step fields (derived)
- CHW, max(1,$clog2(N_CH)): channel index width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command can be accepted this cycle
- cmd_ch  in  CHW  target channel index
- cmd_target  in  W  requested pulse width, cycles
- cmd_step  in  W  max change per frame, cycles; 0 = jump immediately
- pwm  out  N_CH  servo pulse outputs, registered
- busy  out  N_CH  channel i current width != target width
- frame_start  out  1  one-cycle pulse coinciding with first pwm cycle of each frame
- cmd_err  out  1  one-cycle pulse: accepted command had cmd_ch >= N_CH

## Operation
- Frame counter cnt counts 0..FRAME_CYC-1 and wraps to 0. The update cycle is cnt == FRAME_CYC-1.
- Per channel: target, step and cur registers. Reset state: target = cur = PW_INIT, step = 0.
- Handshake:
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
  - cmd_ready = 0 during the update cycle and 1 otherwise.
  - cmd_ready resets to 0 and rises on the first clock edge after rst deasserts.
- On accept with cmd_ch < N_CH:
  - target[ch] <= clamp(cmd_target, PW_MIN, PW_MAX).
  - step[ch] <= cmd_step.
  - Other channels are unchanged.
- On accept with cmd_ch >= N_CH: no register changes; cmd_err pulses high for one cycle on the next cycle.
- Back-to-back commands are allowed, one per cycle. A later command to the same channel overwrites the earlier one.
- Slew, evaluated on the update cycle only, for each channel:
  - d = |target − cur|, computed by comparing before subtracting, so no unsigned wrap.
  - If step == 0 or d <= step: cur <= target.
  - Else: cur <= cur ± step, moving toward target.
  - The new cur takes effect from the frame beginning at the next cnt == 0. It never changes mid-frame, so no runt or stretched pulses.
- PWM:
  - pwm[i] <= (cnt < cur[i]), registered.
  - Each frame, pwm[i] is high for exactly cur[i] consecutive cycles, starting at the frame's first output cycle.
- busy[i] = (cur[i] != target[i]), registered, updated the cycle after any change to cur or target.
- Reset mid-frame: all state returns to reset values asynchronously and outputs drop to 0. The next frame starts at cnt = 0 after rst deasserts.

## Timing
- Reset values: pwm = 0, frame_start = 0, cmd_err = 0, busy = 0, cmd_ready = 0.
- Output latency is one cycle from cnt. Both frame_start and the rising edges of pwm are asserted on the cycle after cnt == 0 is registered.
- Command to visible output:
  - target is written on the accept edge.
  - busy reflects the new target one cycle later.
  - cur changes at the next update cycle.
  - pwm shows the new width in the frame that follows.
- Worst-case ramp from PW_MIN to PW_MAX takes ceil((PW_MAX−PW_MIN)/step) frames.
- Slew arithmetic is one compare plus one add/sub at W bits per channel in a single cycle; no multi-cycle paths.

## Structure
- Package servo_pkg holds:
  - the default constants FRAME_CYC, PW_MIN, PW_MAX, PW_INIT;
  - a clamp function;
  - a channel-state struct {target, step, cur}.
- Sub-module servo_slew_channel is instantiated N_CH times via generate. It holds:
  - one channel's target, step and cur;
  - the clamp and slew logic;
  - the pwm comparator register and busy.
- The top level owns cnt, the handshake, channel decode, cmd_err and frame_start.

## Test plan
Use small parameters FRAME_CYC=100, PW_MIN=10, PW_MAX=20, PW_INIT=15, N_CH=4.
- Reset release, no commands:
  - every frame, each pwm is high exactly 15 cycles;
  - frame_start pulses every 100 cycles, aligned with the pwm rise;
  - busy = 0.
- Command ch1 target=20 step=0, accepted mid-frame:
  - the current frame stays at 15;
  - the next frame is 20;
  - busy[1] is high only until the update;
  - other channels stay at 15.
- Command ch0 target=10 step=2:
  - successive frames show widths 13, 11, 10, 10;
  - busy[0] drops after the update that reaches 10.
- Clamping:
  - target=5 → steady width 10;
  - target=30 → steady width 20.
- Command with cmd_ch=5 in an N_CH=4 build → cmd_err pulses once; no channel changes.
- cmd_valid held high across the update cycle → cmd_ready = 0 on exactly that cycle; the command is accepted on the next cycle.
- Assert rst mid-pulse → pwm goes 0 immediately; after release, widths are back to 15.
